// File: rtl/grad_gen_if.sv
// Pixel-in / gradient-out bundle between the raster source, grad_gen and shiftscale.
interface grad_gen_if;
    logic              in_valid;
    logic              sof;
    logic [7:0]        pix;
    logic              en;
    logic signed [8:0] o1;
    logic signed [8:0] o2;
    logic signed [8:0] o3;
    logic signed [8:0] o4;
    logic signed [8:0] o5;
    logic              frame_done;

    modport master (
        output in_valid, sof, pix,
        input  en, o1, o2, o3, o4, o5, frame_done
    );

    modport slave (
        input  in_valid, sof, pix,
        output en, o1, o2, o3, o4, o5, frame_done
    );
endinterface

// File: rtl/grad_gen.sv
// 3x3 window gradient generator: two line buffers feed a two-column window, and each
// interior centre yields C-L, C-R, C-U, C-D, C-UL as signed 9-bit differences.
module grad_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic      clk,
    input  logic      rst,
    grad_gen_if.slave bus
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;

    logic [7:0] lb1_q [IMG_W];
    logic [7:0] lb2_q [IMG_W];
    logic [7:0] up_rd, mid_rd;

    logic [7:0] w1_top_q, w1_mid_q, w1_bot_q, w2_top_q, w2_mid_q;
    logic [7:0] w1_top_d, w1_mid_d, w1_bot_d, w2_top_d, w2_mid_d;

    logic              win_vld;
    logic              en_q, en_d;
    logic              fd_q, fd_d;
    logic signed [8:0] o_q [5];
    logic signed [8:0] o_d [5];

    function automatic logic signed [8:0] pix_diff(input logic [7:0] c, input logic [7:0] x);
        return signed'({1'b0, c}) - signed'({1'b0, x});
    endfunction

    always_comb begin
        // sof relocates the current pixel to (0,0) before anything is derived from position
        cur_col = bus.sof ? '0 : col_q;
        cur_row = bus.sof ? '0 : row_q;
        up_rd   = lb2_q[cur_col];
        mid_rd  = lb1_q[cur_col];
        win_vld = bus.in_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

        col_d    = col_q;
        row_d    = row_q;
        w1_top_d = w1_top_q;
        w1_mid_d = w1_mid_q;
        w1_bot_d = w1_bot_q;
        w2_top_d = w2_top_q;
        w2_mid_d = w2_mid_q;
        en_d     = win_vld;
        fd_d     = win_vld && (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        o_d      = o_q;

        if (bus.in_valid) begin
            if (cur_col == COL_LAST) begin
                col_d = '0;
                row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
            w2_top_d = w1_top_q;
            w2_mid_d = w1_mid_q;
            w1_top_d = up_rd;
            w1_mid_d = mid_rd;
            w1_bot_d = bus.pix;
        end

        // Column c-1 holds C/U/D, column c-2 holds L/UL, R comes straight from the row r-1 buffer
        if (win_vld) begin
            o_d[0] = pix_diff(w1_mid_q, w2_mid_q);
            o_d[1] = pix_diff(w1_mid_q, mid_rd);
            o_d[2] = pix_diff(w1_mid_q, w1_top_q);
            o_d[3] = pix_diff(w1_mid_q, w1_bot_q);
            o_d[4] = pix_diff(w1_mid_q, w2_top_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            en_q  <= 1'b0;
            fd_q  <= 1'b0;
            o_q   <= '{default: '0};
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            en_q  <= en_d;
            fd_q  <= fd_d;
            o_q   <= o_d;
        end
    end

    // Storage is never cleared; row/col gating keeps stale contents from reaching the outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            w1_top_q <= w1_top_d;
            w1_mid_q <= w1_mid_d;
            w1_bot_q <= w1_bot_d;
            w2_top_q <= w2_top_d;
            w2_mid_q <= w2_mid_d;
            if (bus.in_valid) begin
                lb2_q[cur_col] <= mid_rd;
                lb1_q[cur_col] <= bus.pix;
            end
        end
    end

    assign bus.en         = en_q;
    assign bus.frame_done = fd_q;
    assign bus.o1         = o_q[0];
    assign bus.o2         = o_q[1];
    assign bus.o3         = o_q[2];
    assign bus.o4         = o_q[3];
    assign bus.o5         = o_q[4];
endmodule

// File: tb/tb_grad_gen.sv
// Directed-plus-random bench for grad_gen on a 5x4 frame, checked against an image-array model.
module tb_grad_gen;
    localparam int W = 5;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    grad_gen_if bus ();

    grad_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int img [H][W];
    int mr, mc;
    int e_en, e_fd;
    int e_o [5];
    int en_cnt, fd_cnt;
    bit ramp_chk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_outs();
        chk("en", bus.en, e_en);
        chk("frame_done", bus.frame_done, e_fd);
        chk("o1", bus.o1, e_o[0]);
        chk("o2", bus.o2, e_o[1]);
        chk("o3", bus.o3, e_o[2]);
        chk("o4", bus.o4, e_o[3]);
        chk("o5", bus.o5, e_o[4]);
        if (bus.en === 1'b1) en_cnt++;
        if (bus.frame_done === 1'b1) fd_cnt++;
        if (ramp_chk && bus.en === 1'b1) begin
            chk("ramp_o1", bus.o1, 10);
            chk("ramp_o2", bus.o2, -10);
            chk("ramp_o3", bus.o3, 0);
            chk("ramp_o4", bus.o4, 0);
            chk("ramp_o5", bus.o5, 10);
        end
    endtask

    task automatic model_reset();
        mr = 0;
        mc = 0;
        e_en = 0;
        e_fd = 0;
        for (int k = 0; k < 5; k++) e_o[k] = 0;
    endtask

    // One clock: drive inputs, advance the image model, then check just after the edge
    task automatic step(input bit v, input bit s, input int p);
        int c;
        bus.in_valid = v;
        bus.sof      = s;
        bus.pix      = p[7:0];
        e_en = 0;
        e_fd = 0;
        if (v) begin
            if (s) begin
                mr = 0;
                mc = 0;
            end
            img[mr][mc] = p;
            if (mr >= 2 && mc >= 2) begin
                c = img[mr-1][mc-1];
                e_o[0] = c - img[mr-1][mc-2];
                e_o[1] = c - img[mr-1][mc];
                e_o[2] = c - img[mr-2][mc-1];
                e_o[3] = c - img[mr][mc-1];
                e_o[4] = c - img[mr-2][mc-2];
                e_en = 1;
                e_fd = (mr == H-1 && mc == W-1) ? 1 : 0;
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr = (mr == H-1) ? 0 : mr + 1;
            end
        end
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.sof = 1'b0;
        bus.pix = 8'hAA;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
        check_outs();
    endtask

    function automatic int pix_val(input int kind, input int r, input int c);
        case (kind)
            0: return 100;
            1: return c * 10;
            2: return (r == 1 && c == 1) ? 255 : 0;
            3: return 50;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic frame(input int kind, input int gap_pct, input bit use_sof);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                while (gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct)
                    step(1'b0, 1'b0, int'($urandom_range(0, 255)));
                step(1'b1, use_sof && r == 0 && c == 0, pix_val(kind, r, c));
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.sof = 1'b0;
        bus.pix = '0;
        ramp_chk = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        en_cnt = 0; fd_cnt = 0;
        frame(0, 0, 1'b1);
        chk("flat_en_count", en_cnt, 6);
        chk("flat_fd_count", fd_cnt, 1);

        ramp_chk = 1'b1;
        en_cnt = 0;
        frame(1, 0, 1'b1);
        chk("ramp_en_count", en_cnt, 6);

        en_cnt = 0; fd_cnt = 0;
        frame(1, 50, 1'b1);
        chk("ramp_gap_en_count", en_cnt, 6);
        chk("ramp_gap_fd_count", fd_cnt, 1);
        ramp_chk = 1'b0;

        en_cnt = 0;
        frame(2, 0, 1'b1);
        chk("bright_en_count", en_cnt, 6);

        for (int i = 0; i < 12; i++) step(1'b1, i == 0, pix_val(4, 0, 0));
        do_reset();
        en_cnt = 0; fd_cnt = 0;
        frame(3, 0, 1'b0);
        chk("rst_en_count", en_cnt, 6);
        chk("rst_fd_count", fd_cnt, 1);

        for (int i = 0; i < 8; i++) step(1'b1, i == 0, pix_val(4, 0, 0));
        en_cnt = 0; fd_cnt = 0;
        frame(4, 0, 1'b1);
        chk("sof_en_count", en_cnt, 6);
        chk("sof_fd_count", fd_cnt, 1);

        for (int f = 0; f < 3; f++) begin
            en_cnt = 0;
            frame(4, 30, f == 0);
            chk("rand_en_count", en_cnt, 6);
        end
        step(1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
